alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage directly downstream of the decode/ALU pipeline register.
//  Consumes forwarded operands, immediate and ALU op; produces the registered
//  result, write-back address and write enable for the ALU/MEM register.
//  RV32I ALU ops complete in 1 cycle. RV32M DIV/DIVU/REM/REMU run on an
//  iterative restoring divider and raise busy, which the hazard unit uses to stall.
// PARAMETERS
//  XLEN   32  operand/result width
//  OP_W   5   ALU op width (matches ALUControlBus)
//  ADDR_W 5   register address width
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high
//  in_valid     in   1       op/operands valid this cycle
//  flush        in   1       kill in-flight op (branch redirect)
//  op           in   OP_W    ALU op code, see encoding below
//  src1         in   XLEN    operand 1 (post-forwarding)
//  src2         in   XLEN    operand 2 (post-forwarding)
//  imm          in   XLEN    immediate value
//  use_imm      in   1       1: operand B = imm, 0: operand B = src2
//  wb_addr_in   in   ADDR_W  destination register
//  wen_in       in   1       register write enable
//  result       out  XLEN    registered result
//  out_valid    out  1       result/wb_addr_out/wen_out valid this cycle
//  wb_addr_out  out  ADDR_W  destination register, aligned with result
//  wen_out      out  1       write enable, aligned with result (0 when !out_valid)
//  busy         out  1       divider running; stall upstream
// BEHAVIOUR
//  Encoding: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,
//   10 MUL,11 MULH,12 MULHSU,13 MULHU,14 DIV,15 DIVU,16 REM,17 REMU;
//   18..31 -> result 0, still valid.
//  Reset: result=0, out_valid=0, wb_addr_out=0, wen_out=0, busy=0, FSM=IDLE,
//   counter=0. Reset mid-division aborts it; no result is emitted.
//  Arithmetic: wrap modulo 2^XLEN; shift amount = B[4:0]; SLT signed, SLTU
//   unsigned; MULH/MULHSU/MULHU give the upper XLEN bits of the 2*XLEN product.
//  FSM: IDLE, DIV_RUN, DIV_DONE.
//  IDLE, in_valid && op not divide: registered at the next edge; out_valid=1
//   for exactly 1 cycle (latency 1). Back-to-back accepts: 1 op per cycle.
//  IDLE, in_valid && divide, divisor 0: handled in 1 cycle, no iteration.
//   DIV/DIVU -> all ones; REM/REMU -> dividend.
//  IDLE, signed divide with 0x80000000 / -1: handled in 1 cycle.
//   DIV -> 0x80000000; REM -> 0.
//  IDLE, other divides: go to DIV_RUN. Latch |operands|, sign flags, op,
//   wb_addr and wen. busy=1 from the next cycle.
//  DIV_RUN: 1 quotient bit per cycle for XLEN cycles, then DIV_DONE.
//  DIV_DONE: fix quotient/remainder signs. At the next edge: out_valid=1,
//   busy=0, FSM=IDLE. Latency from accept edge = XLEN+2 cycles.
//   Busy high for XLEN+1 cycles.
//  Signs: quotient negative iff operand signs differ; remainder takes the
//   dividend's sign.
//  While busy: in_valid is ignored; upstream holds its inputs.
//  flush: in DIV_RUN/DIV_DONE go to IDLE, busy=0 and no result is emitted.
//   If flush and in_valid occur in the same cycle, flush wins and nothing is
//   accepted. out_valid is 0 the cycle after flush.
//  out_valid=0: result and wb_addr_out hold their last values; wen_out=0.
// TESTING
//  ADD 7+(-3); SUB 5-9 -> result 4, then 0xFFFFFFFC; out_valid 1 cycle after each.
//  SRA 0x80000000 by B=0x21; SLTU 1 vs 0xFFFFFFFF -> 0xC0000000, then 1.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*2 -> 1.
//  DIV -7/2, wb_addr=5 -> busy 33 cycles; then out_valid with result 0xFFFFFFFD,
//   wb_addr_out=5. REM -7/2 -> 0xFFFFFFFF.
//  Corner divides: DIVU 9/0 -> 0xFFFFFFFF; REM 9/0 -> 9;
//   DIV 0x80000000/-1 -> 0x80000000, latency 1.
//  DIVU 100/7 interrupted by flush at cycle 10 (and separately by reset):
//   busy drops next cycle, no out_valid; ADD accepted after that completes normally.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Issue/result bus between the decode pipeline register, the execute stage
// and the ALU/MEM register.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid;
  logic              flush;
  logic [OP_W-1:0]   op;
  logic [XLEN-1:0]   src1;
  logic [XLEN-1:0]   src2;
  logic [XLEN-1:0]   imm;
  logic              use_imm;
  logic [ADDR_W-1:0] wb_addr_in;
  logic              wen_in;
  logic [XLEN-1:0]   result;
  logic              out_valid;
  logic [ADDR_W-1:0] wb_addr_out;
  logic              wen_out;
  logic              busy;

  modport master (
    output in_valid, flush, op, src1, src2, imm, use_imm, wb_addr_in, wen_in,
    input  result, out_valid, wb_addr_out, wen_out, busy
  );

  modport slave (
    input  in_valid, flush, op, src1, src2, imm, use_imm, wb_addr_in, wen_in,
    output result, out_valid, wb_addr_out, wen_out, busy
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle RV32I/RV32M-multiply ALU plus an iterative
// restoring divider that stalls upstream through busy.
module alu_exec_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned OP_W   = 5,
  parameter int unsigned ADDR_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);
  localparam int unsigned SH_W   = $clog2(XLEN);
  localparam int unsigned CNT_W  = $clog2(XLEN);
  localparam int unsigned PROD_W = 2 * XLEN + 2;

  localparam logic [OP_W-1:0] OP_ADD    = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SLL    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SLT    = OP_W'(3);
  localparam logic [OP_W-1:0] OP_SLTU   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR    = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL    = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA    = OP_W'(7);
  localparam logic [OP_W-1:0] OP_OR     = OP_W'(8);
  localparam logic [OP_W-1:0] OP_AND    = OP_W'(9);
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(10);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(12);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_DIV    = OP_W'(14);
  localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_REM    = OP_W'(16);
  localparam logic [OP_W-1:0] OP_REMU   = OP_W'(17);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV_RUN,
    S_DIV_DONE
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   result_q;
  logic              out_valid_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic              wen_out_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   div_quot_q;
  logic [XLEN-1:0]   div_rem_q;
  logic [XLEN-1:0]   div_divisor_q;
  logic              div_q_neg_q;
  logic              div_r_neg_q;
  logic              div_is_rem_q;
  logic [ADDR_W-1:0] div_addr_q;
  logic              div_wen_q;

  logic [XLEN-1:0]   opa;
  logic [XLEN-1:0]   opb;
  logic [SH_W-1:0]   shamt;
  logic              is_div;
  logic              is_sdiv;
  logic              is_rem;
  logic              div_by_zero;
  logic              div_ovf;
  logic              accept;
  logic [XLEN-1:0]   alu_d;
  logic [XLEN-1:0]   opa_abs;
  logic [XLEN-1:0]   opb_abs;

  logic              mul_a_sx;
  logic              mul_b_sx;
  logic signed [PROD_W-1:0] mul_a;
  logic signed [PROD_W-1:0] mul_b;
  logic signed [PROD_W-1:0] prod;
  logic              unused_prod_bits;

  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem_d;
  logic [XLEN-1:0]   div_quot_d;
  logic [XLEN-1:0]   div_final_d;

  assign opa     = bus.src1;
  assign opb     = bus.use_imm ? bus.imm : bus.src2;
  assign shamt   = opb[SH_W-1:0];
  assign is_div  = (bus.op == OP_DIV) || (bus.op == OP_DIVU) ||
                   (bus.op == OP_REM) || (bus.op == OP_REMU);
  assign is_sdiv = (bus.op == OP_DIV) || (bus.op == OP_REM);
  assign is_rem  = (bus.op == OP_REM) || (bus.op == OP_REMU);
  assign div_by_zero = (opb == '0);
  assign div_ovf = is_sdiv && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
  assign accept  = bus.in_valid && !bus.flush;
  assign opa_abs = (is_sdiv && opa[XLEN-1]) ? -opa : opa;
  assign opb_abs = (is_sdiv && opb[XLEN-1]) ? -opb : opb;

  // One widened signed multiply serves all four multiply variants.
  assign mul_a_sx = ((bus.op == OP_MULH) || (bus.op == OP_MULHSU)) && opa[XLEN-1];
  assign mul_b_sx = (bus.op == OP_MULH) && opb[XLEN-1];
  assign mul_a    = {{(XLEN+2){mul_a_sx}}, opa};
  assign mul_b    = {{(XLEN+2){mul_b_sx}}, opb};
  assign prod     = mul_a * mul_b;
  assign unused_prod_bits = ^prod[PROD_W-1:2*XLEN];

  always_comb begin
    alu_d = '0;
    case (bus.op)
      OP_ADD:    alu_d = opa + opb;
      OP_SUB:    alu_d = opa - opb;
      OP_SLL:    alu_d = opa << shamt;
      OP_SLT:    alu_d = XLEN'($signed(opa) < $signed(opb));
      OP_SLTU:   alu_d = XLEN'(opa < opb);
      OP_XOR:    alu_d = opa ^ opb;
      OP_SRL:    alu_d = opa >> shamt;
      OP_SRA:    alu_d = XLEN'($signed(opa) >>> shamt);
      OP_OR:     alu_d = opa | opb;
      OP_AND:    alu_d = opa & opb;
      OP_MUL:    alu_d = prod[XLEN-1:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  alu_d = prod[2*XLEN-1:XLEN];
      // Only the single-cycle divide corners reach the result mux.
      OP_DIV,
      OP_DIVU:   alu_d = div_by_zero ? '1 : opa;
      OP_REM,
      OP_REMU:   alu_d = div_by_zero ? opa : '0;
      default:   alu_d = '0;
    endcase
  end

  // Restoring divide step: shift in the next dividend bit, subtract if it fits.
  assign div_shift  = {div_rem_q, div_quot_q[XLEN-1]};
  assign div_diff   = div_shift - {1'b0, div_divisor_q};
  assign div_ge     = !div_diff[XLEN];
  assign div_rem_d  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_quot_d = {div_quot_q[XLEN-2:0], div_ge};
  assign div_final_d = div_is_rem_q ? (div_r_neg_q ? -div_rem_q  : div_rem_q)
                                    : (div_q_neg_q ? -div_quot_q : div_quot_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      result_q      <= '0;
      out_valid_q   <= 1'b0;
      wb_addr_q     <= '0;
      wen_out_q     <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= '0;
      div_quot_q    <= '0;
      div_rem_q     <= '0;
      div_divisor_q <= '0;
      div_q_neg_q   <= 1'b0;
      div_r_neg_q   <= 1'b0;
      div_is_rem_q  <= 1'b0;
      div_addr_q    <= '0;
      div_wen_q     <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      wen_out_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!is_div || div_by_zero || div_ovf) begin
              result_q    <= alu_d;
              out_valid_q <= 1'b1;
              wb_addr_q   <= bus.wb_addr_in;
              wen_out_q   <= bus.wen_in;
            end else begin
              state_q       <= S_DIV_RUN;
              busy_q        <= 1'b1;
              cnt_q         <= '0;
              div_quot_q    <= opa_abs;
              div_rem_q     <= '0;
              div_divisor_q <= opb_abs;
              div_q_neg_q   <= is_sdiv && (opa[XLEN-1] ^ opb[XLEN-1]);
              div_r_neg_q   <= is_sdiv && opa[XLEN-1];
              div_is_rem_q  <= is_rem;
              div_addr_q    <= bus.wb_addr_in;
              div_wen_q     <= bus.wen_in;
            end
          end
        end
        S_DIV_RUN: begin
          if (bus.flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            div_rem_q  <= div_rem_d;
            div_quot_q <= div_quot_d;
            cnt_q      <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(XLEN - 1)) begin
              state_q <= S_DIV_DONE;
            end
          end
        end
        S_DIV_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          if (!bus.flush) begin
            result_q    <= div_final_d;
            out_valid_q <= 1'b1;
            wb_addr_q   <= div_addr_q;
            wen_out_q   <= div_wen_q;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result      = result_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.wb_addr_out = wb_addr_q;
  assign bus.wen_out     = wen_out_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: vector table for single-cycle ops plus
// hand sequences for the divider, flush and reset corners.
module tb_alu_exec_unit;
  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
  localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17;
  localparam int NVEC = 22;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        use_imm;
    logic [4:0]  addr;
    logic        wen;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs [NVEC];

  alu_exec_unit_if #(.XLEN(32), .OP_W(5), .ADDR_W(5)) bus ();

  alu_exec_unit #(.XLEN(32), .OP_W(5), .ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic use_imm, input logic [4:0] addr,
                       input logic wen);
    bus.in_valid   = 1'b1;
    bus.op         = op;
    bus.src1       = a;
    bus.src2       = b;
    bus.imm        = imm;
    bus.use_imm    = use_imm;
    bus.wb_addr_in = addr;
    bus.wen_in     = wen;
  endtask

  task automatic run_div(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] addr, input logic [31:0] exp);
    int  busy_cnt;
    int  lat;
    bit  got;
    busy_cnt = 0;
    lat      = 0;
    got      = 1'b0;
    @(negedge clk);
    drive(op, a, b, 32'h0, 1'b0, addr, 1'b1);
    // Inputs stay held while busy, as the stalled upstream would do.
    for (int k = 1; k <= 100 && !got; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1'b1;
        lat = k;
      end else if (bus.busy) begin
        busy_cnt++;
      end
    end
    bus.in_valid = 1'b0;
    chk({name, "_done"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'd34);
    chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    chk({name, "_result"}, bus.result, exp);
    chk({name, "_wb_addr"}, 32'(bus.wb_addr_out), 32'(addr));
    chk({name, "_wen"}, 32'(bus.wen_out), 32'd1);
    chk({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk({name, "_valid_one_cycle"}, 32'(bus.out_valid), 32'd0);
    chk({name, "_result_hold"}, bus.result, exp);
  endtask

  // DIVU 100/7 cut short after 10 busy cycles by flush (use_reset=0) or reset.
  task automatic abort_div(input string name, input bit use_reset);
    int stray;
    stray = 0;
    @(negedge clk);
    drive(OP_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 5'd9, 1'b1);
    for (int k = 1; k <= 10; k++) @(negedge clk);
    chk({name, "_busy_before"}, 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b0;
    if (use_reset) reset = 1'b1;
    else bus.flush = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    bus.flush = 1'b0;
    chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({name, "_no_valid"}, 32'(bus.out_valid), 32'd0);
    if (use_reset) chk({name, "_result_cleared"}, bus.result, 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) stray++;
    end
    chk({name, "_quiet"}, 32'(stray), 32'd0);
    drive(OP_ADD, 32'd2, 32'd3, 32'h0, 1'b0, 5'd12, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({name, "_add_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_add_result"}, bus.result, 32'd5);
    chk({name, "_add_addr"}, 32'(bus.wb_addr_out), 32'd12);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{OP_ADD,    32'd7,         32'hFFFFFFFD, 32'h0,        1'b0, 5'd1,  1'b1, 32'd4};
    vecs[1]  = '{OP_SUB,    32'd5,         32'h12345678, 32'd9,        1'b1, 5'd2,  1'b1, 32'hFFFFFFFC};
    vecs[2]  = '{OP_SLL,    32'd1,         32'h21,       32'h0,        1'b0, 5'd3,  1'b1, 32'd2};
    vecs[3]  = '{OP_SLT,    32'hFFFFFFFF,  32'd1,        32'h0,        1'b0, 5'd4,  1'b1, 32'd1};
    vecs[4]  = '{OP_SLTU,   32'd1,         32'hFFFFFFFF, 32'h0,        1'b0, 5'd5,  1'b1, 32'd1};
    vecs[5]  = '{OP_SLTU,   32'hFFFFFFFF,  32'd1,        32'h0,        1'b0, 5'd6,  1'b1, 32'd0};
    vecs[6]  = '{OP_XOR,    32'hF0F0F0F0,  32'hFF00FF00, 32'h0,        1'b0, 5'd7,  1'b1, 32'h0FF00FF0};
    vecs[7]  = '{OP_SRL,    32'h80000000,  32'd4,        32'h0,        1'b0, 5'd8,  1'b1, 32'h08000000};
    vecs[8]  = '{OP_SRA,    32'h80000000,  32'h21,       32'h0,        1'b0, 5'd9,  1'b1, 32'hC0000000};
    vecs[9]  = '{OP_OR,     32'h0F,        32'hF0,       32'h0,        1'b0, 5'd10, 1'b0, 32'hFF};
    vecs[10] = '{OP_AND,    32'hFF00,      32'h0FF0,     32'h0,        1'b0, 5'd11, 1'b1, 32'h0F00};
    vecs[11] = '{OP_MUL,    32'h00010000,  32'h00010001, 32'h0,        1'b0, 5'd12, 1'b1, 32'h00010000};
    vecs[12] = '{OP_MULH,   32'h80000000,  32'h80000000, 32'h0,        1'b0, 5'd13, 1'b1, 32'h40000000};
    vecs[13] = '{OP_MULHSU, 32'hFFFFFFFF,  32'd2,        32'h0,        1'b0, 5'd14, 1'b1, 32'hFFFFFFFF};
    vecs[14] = '{OP_MULHU,  32'hFFFFFFFF,  32'd2,        32'h0,        1'b0, 5'd15, 1'b1, 32'd1};
    vecs[15] = '{OP_DIVU,   32'd9,         32'd0,        32'h0,        1'b0, 5'd16, 1'b1, 32'hFFFFFFFF};
    vecs[16] = '{OP_REM,    32'd9,         32'd0,        32'h0,        1'b0, 5'd17, 1'b1, 32'd9};
    vecs[17] = '{OP_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h0,        1'b0, 5'd18, 1'b1, 32'h80000000};
    vecs[18] = '{OP_REM,    32'h80000000,  32'hFFFFFFFF, 32'h0,        1'b0, 5'd19, 1'b1, 32'd0};
    vecs[19] = '{5'd20,     32'd5,         32'd6,        32'h0,        1'b0, 5'd31, 1'b1, 32'd0};
    vecs[20] = '{OP_SLT,    32'd1,         32'hFFFFFFFF, 32'h0,        1'b0, 5'd20, 1'b1, 32'd0};
    vecs[21] = '{OP_ADD,    32'hFFFFFFFF,  32'h0,        32'd1,        1'b1, 5'd21, 1'b1, 32'd0};

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.op = '0;
    bus.src1 = '0;
    bus.src2 = '0;
    bus.imm = '0;
    bus.use_imm = 1'b0;
    bus.wb_addr_in = '0;
    bus.wen_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_result", bus.result, 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_wb_addr", 32'(bus.wb_addr_out), 32'd0);
    chk("reset_wen", 32'(bus.wen_out), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    // Back-to-back single-cycle ops: each is checked while the next one issues.
    for (int i = 0; i <= NVEC; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk($sformatf("vec%0d_valid", i - 1), 32'(bus.out_valid), 32'd1);
        chk($sformatf("vec%0d_result", i - 1), bus.result, vecs[i-1].exp);
        chk($sformatf("vec%0d_wb_addr", i - 1), 32'(bus.wb_addr_out), 32'(vecs[i-1].addr));
        chk($sformatf("vec%0d_wen", i - 1), 32'(bus.wen_out), 32'(vecs[i-1].wen));
      end
      if (i < NVEC) begin
        drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].use_imm,
              vecs[i].addr, vecs[i].wen);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("idle_valid_low", 32'(bus.out_valid), 32'd0);
    chk("idle_wen_low", 32'(bus.wen_out), 32'd0);
    chk("idle_result_hold", bus.result, vecs[NVEC-1].exp);
    chk("idle_addr_hold", 32'(bus.wb_addr_out), 32'(vecs[NVEC-1].addr));

    // Flush in the same cycle as in_valid: nothing accepted.
    drive(OP_ADD, 32'd1, 32'd1, 32'h0, 1'b0, 5'd3, 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_wins_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_wins_wen", 32'(bus.wen_out), 32'd0);

    run_div("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD);
    run_div("rem_m7_2", OP_REM, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF);
    run_div("div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9, 5'd7, 32'hFFFFFFF2);
    run_div("rem_100_m7", OP_REM, 32'd100, 32'hFFFFFFF9, 5'd8, 32'd2);
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 5'd10, 32'd14);
    run_div("remu_big", OP_REMU, 32'hFFFFFFFF, 32'd10, 5'd11, 32'd5);

    abort_div("flush_div", 1'b0);
    abort_div("reset_div", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
